// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM receive path: FSM encoding, slot count
// and slot index codes matching the transmit mux select.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_SLOTS = 4;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter: load-to-1 when a sync word is taken as slot 0,
// advance on each in-frame word, hold otherwise.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [1:0] slot_o
);

    logic [1:0] slot_q;
    logic [1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = SLOT_B;
        end else if (adv_i) begin
            slot_d = slot_q + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_A;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-slot TDM demultiplexer: locks on sync, collects a frame in shadow registers
// and commits all four channels at once. Optional error counter: TDM_DEMUX_ERRCNT_EN.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    tdm_state_e       state_q;
    tdm_state_e       state_d;
    logic [1:0]       slot_w;
    logic [WIDTH-1:0] shadow_q [0:TDM_SLOTS-2];
    logic [WIDTH-1:0] out_a_q, out_b_q, out_c_q, out_d_q;
    logic             frame_valid_q;
    logic             sync_err_q;

    logic is_locked;
    logic at_slot0;
    logic take_first;
    logic advance;
    logic commit;
    logic early_sync;
    logic missing_sync;

    assign is_locked    = (state_q == LOCKED);
    assign at_slot0     = (slot_w == SLOT_A);
    // A sync word always restarts the frame, whether hunting or re-aligning.
    assign take_first   = din_valid & sync;
    assign advance      = din_valid & is_locked & ~sync & ~at_slot0;
    assign commit       = advance & (slot_w == SLOT_D);
    assign early_sync   = din_valid & is_locked & sync & ~at_slot0;
    assign missing_sync = din_valid & is_locked & ~sync & at_slot0;

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (take_first),
        .adv_i  (advance),
        .slot_o (slot_w)
    );

    always_comb begin
        state_d = state_q;
        if (take_first) begin
            state_d = LOCKED;
        end else if (missing_sync) begin
            state_d = HUNT;
        end
    end

    // NOTE: the shadow registers are explicitly reset so a fresh lock never
    // exposes stale words; this is a tiny register file, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            shadow_q[0]   <= '0;
            shadow_q[1]   <= '0;
            shadow_q[2]   <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_c_q       <= '0;
            out_d_q       <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_valid_q <= commit;
            sync_err_q    <= early_sync | missing_sync;
            if (take_first) begin
                shadow_q[0] <= din;
            end else if (advance) begin
                case (slot_w)
                    SLOT_B:  shadow_q[1] <= din;
                    SLOT_C:  shadow_q[2] <= din;
                    default: ;
                endcase
            end
            if (commit) begin
                out_a_q <= shadow_q[0];
                out_b_q <= shadow_q[1];
                out_c_q <= shadow_q[2];
                out_d_q <= din;
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((early_sync | missing_sync) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_c       = out_c_q;
    assign out_d       = out_d_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_w;
    assign locked      = is_locked;
    assign sync_err    = sync_err_q;

endmodule
